// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM.
// Sequences each instruction and drives the ALU op code and the datapath mux/strobe controls.
module mips_multicycle_ctrl #(
    parameter bit ADDR_DONT_CARE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state
);
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned ST_W  = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_NOR = 6'b100111;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;
    localparam logic [OP_W-1:0] FN_SLL = 6'b000000;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b1110;
    localparam logic [ALU_W-1:0] ALU_NOP = 4'b1111;

    localparam logic       SEL1_DC = ADDR_DONT_CARE;
    localparam logic [1:0] SEL2_DC = {2{ADDR_DONT_CARE}};

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ALU_W-1:0] rtype_alu;
    logic             funct_ok;

    // State register; reset aborts any in-flight access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = ST_W'(state_q);

    // R-type funct to ALU operation.
    always_comb begin
        rtype_alu = ALU_NOP;
        funct_ok  = 1'b1;
        case (funct)
            FN_ADD:  rtype_alu = ALU_ADD;
            FN_SUB:  rtype_alu = ALU_SUB;
            FN_AND:  rtype_alu = ALU_AND;
            FN_NOR:  rtype_alu = ALU_NOR;
            FN_SLT:  rtype_alu = ALU_SLT;
            FN_SLL:  rtype_alu = ALU_SLL;
            default: funct_ok  = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_RTYPE_EX: state_d = funct_ok ? S_RTYPE_WB : S_FETCH;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BEQ_EX:   state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the current state, with the Mealy terms
    // (ir/pc load on mem_ready, branch on zero) and a reset override on top.
    always_comb begin
        alu_control = ALU_ADD;
        alu_src_a   = SEL1_DC;
        alu_src_b   = SEL2_DC;
        pc_source   = SEL2_DC;
        pc_write    = 1'b0;
        iord        = SEL1_DC;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = SEL1_DC;
        mem_to_reg  = SEL1_DC;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                iord      = 1'b0;
                alu_src_a = 1'b0;
                alu_src_b = 2'b01;
                pc_source = 2'b00;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 1'b0;
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b00;
                alu_control = rtype_alu;
                illegal_op  = !funct_ok;
            end
            S_RTYPE_WB: begin
                alu_control = rtype_alu;
                reg_write   = 1'b1;
                reg_dst     = 1'b1;
                mem_to_reg  = 1'b0;
            end
            S_BEQ_EX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b00;
                alu_control = ALU_SUB;
                pc_source   = 2'b01;
                pc_write    = zero;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            default: begin
                alu_control = ALU_ADD;
            end
        endcase
        if (!rst_n) begin
            alu_control = '0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            pc_source   = 2'b00;
            pc_write    = 1'b0;
            iord        = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            illegal_op  = 1'b0;
        end
    end

endmodule
